// File: rtl/writeback_queue_if.sv
// Writeback queue bus: execute-side push handshake, bank write port and operand-fetch snoop.
// master drives the queue (execute/bank/fetch side); slave is the queue itself.
interface writeback_queue_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dir;
  logic [DATA_W-1:0] in_data;
  logic              bank_stall;
  logic [ADDR_W-1:0] dir_esc;
  logic [DATA_W-1:0] data;
  logic              signal_esc;
  logic [ADDR_W-1:0] dir_A;
  logic              signal_read;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CntW-1:0]   count;

  modport master (
    output in_valid, in_dir, in_data, bank_stall, dir_A, signal_read,
    input  in_ready, dir_esc, data, signal_esc, fwd_hit, fwd_data, count
  );

  modport slave (
    input  in_valid, in_dir, in_data, bank_stall, dir_A, signal_read,
    output in_ready, dir_esc, data, signal_esc, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/writeback_queue.sv
// Writeback FIFO in front of the scalar register bank, draining one entry per cycle
// into a registered write port and forwarding pending results to operand fetch.
module writeback_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  writeback_queue_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] dir_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] dir_esc_q;
  logic [DATA_W-1:0] data_esc_q;
  logic              signal_esc_q;
  logic              in_ready;
  logic              push, pop;
  logic [PtrW-1:0]   fwd_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Ready depends only on registered count, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q < CntW'(DEPTH));
  assign push     = bus.in_valid & in_ready;
  assign pop      = (count_q != '0) & ~bus.bank_stall;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dir_mem[wr_ptr_q]  <= bus.in_dir;
      data_mem[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dir_esc_q    <= '0;
      data_esc_q   <= '0;
      signal_esc_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      signal_esc_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        dir_esc_q  <= dir_mem[rd_ptr_q];
        data_esc_q <= data_mem[rd_ptr_q];
      end
    end
  end

  // Oldest candidate first so younger matches overwrite: output register, then head..tail.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    if (signal_esc_q && (dir_esc_q == bus.dir_A)) begin
      fwd_hit  = 1'b1;
      fwd_data = data_esc_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (dir_mem[fwd_idx] == bus.dir_A)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
    if (!bus.signal_read) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.dir_esc    = dir_esc_q;
  assign bus.data       = data_esc_q;
  assign bus.signal_esc = signal_esc_q;
  assign bus.fwd_hit    = fwd_hit;
  assign bus.fwd_data   = fwd_data;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus randomized traffic against a
// queue-based reference model of the pending-write set.
module tb_writeback_queue;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) wb ();

  writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (wb)
  );

  always #5 clk = ~clk;

  // Reference model: queued entries in arrival order plus the bank write register.
  logic [ADDR_W-1:0] q_dir  [$];
  logic [DATA_W-1:0] q_data [$];
  logic              m_esc;
  logic [ADDR_W-1:0] m_dir;
  logic [DATA_W-1:0] m_data;

  task automatic model_reset();
    q_dir.delete();
    q_data.delete();
    m_esc  = 1'b0;
    m_dir  = '0;
    m_data = '0;
  endtask

  // Advance one rising edge, updating the model from the inputs present at the edge.
  task automatic tick();
    logic do_push, do_pop;
    @(posedge clk);
    do_push = wb.in_valid && (q_dir.size() < DEPTH);
    do_pop  = (q_dir.size() > 0) && !wb.bank_stall;
    if (do_pop) begin
      m_esc  = 1'b1;
      m_dir  = q_dir.pop_front();
      m_data = q_data.pop_front();
    end else begin
      m_esc = 1'b0;
    end
    if (do_push) begin
      q_dir.push_back(wb.in_dir);
      q_data.push_back(wb.in_data);
    end
    #1;
  endtask

  function automatic void model_fwd(output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (!wb.signal_read) return;
    for (int i = int'(q_dir.size()) - 1; i >= 0; i--) begin
      if (q_dir[i] == wb.dir_A) begin
        hit = 1'b1;
        d   = q_data[i];
        return;
      end
    end
    if (m_esc && (m_dir == wb.dir_A)) begin
      hit = 1'b1;
      d   = m_data;
    end
  endfunction

  task automatic test_reset();
    wb.in_valid = 1'b0; wb.in_dir = '0; wb.in_data = '0; wb.bank_stall = 1'b0;
    wb.dir_A = '0; wb.signal_read = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (wb.signal_esc !== 1'b0) begin
      n_errors++; $display("FAIL reset_esc: got %0h want 0", wb.signal_esc);
    end
    n_checks++;
    if (wb.count !== '0) begin
      n_errors++; $display("FAIL reset_count: got %0h want 0", wb.count);
    end
    n_checks++;
    if (wb.dir_esc !== '0 || wb.data !== '0) begin
      n_errors++; $display("FAIL reset_out: got %0h/%0h want 0/0", wb.dir_esc, wb.data);
    end
    n_checks++;
    if (wb.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready: got %0h want 1", wb.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_push();
    wb.in_valid = 1'b1; wb.in_dir = ADDR_W'(5); wb.in_data = DATA_W'(6);
    tick();
    wb.in_valid = 1'b0;
    n_checks++;
    if (wb.signal_esc !== 1'b0 || wb.count !== CNT_W'(1)) begin
      n_errors++; $display("FAIL single_edge1: got esc=%0h cnt=%0h want 0/1", wb.signal_esc, wb.count);
    end
    tick();
    n_checks++;
    if (wb.signal_esc !== 1'b1 || wb.dir_esc !== ADDR_W'(5) || wb.data !== DATA_W'(6)) begin
      n_errors++;
      $display("FAIL single_edge2: got esc=%0h dir=%0h data=%0h want 1/5/6",
               wb.signal_esc, wb.dir_esc, wb.data);
    end
    n_checks++;
    if (wb.count !== '0) begin
      n_errors++; $display("FAIL single_count: got %0h want 0", wb.count);
    end
    tick();
    n_checks++;
    if (wb.signal_esc !== 1'b0) begin
      n_errors++; $display("FAIL single_edge3: got %0h want 0", wb.signal_esc);
    end
  endtask

  task automatic test_stall_fill();
    wb.bank_stall = 1'b1;
    wb.in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb.in_dir  = ADDR_W'(i + 1);
      wb.in_data = DATA_W'(8'h11 * (i + 1));
      tick();
    end
    wb.in_dir = ADDR_W'(6); wb.in_data = DATA_W'(8'h66);
    n_checks++;
    if (wb.count !== CNT_W'(4) || wb.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL fill_full: got cnt=%0h rdy=%0h want 4/0", wb.count, wb.in_ready);
    end
    tick();
    n_checks++;
    if (wb.count !== CNT_W'(4) || wb.signal_esc !== 1'b0) begin
      n_errors++; $display("FAIL fill_held_off: got cnt=%0h esc=%0h want 4/0", wb.count, wb.signal_esc);
    end
    wb.in_valid   = 1'b0;
    wb.bank_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (wb.signal_esc !== 1'b1 || wb.dir_esc !== ADDR_W'(i + 1) ||
          wb.data !== DATA_W'(8'h11 * (i + 1))) begin
        n_errors++;
        $display("FAIL fill_drain%0d: got esc=%0h dir=%0h data=%0h want 1/%0h/%0h", i,
                 wb.signal_esc, wb.dir_esc, wb.data, i + 1, 8'h11 * (i + 1));
      end
      if (i == 0) begin
        n_checks++;
        if (wb.in_ready !== 1'b1) begin
          n_errors++; $display("FAIL fill_ready_after_pop: got %0h want 1", wb.in_ready);
        end
      end
    end
    tick();
    n_checks++;
    if (wb.signal_esc !== 1'b0 || wb.count !== '0) begin
      n_errors++; $display("FAIL fill_end: got esc=%0h cnt=%0h want 0/0", wb.signal_esc, wb.count);
    end
  endtask

  task automatic test_forward();
    wb.bank_stall = 1'b1;
    wb.in_valid = 1'b1; wb.in_dir = ADDR_W'(3); wb.in_data = DATA_W'(8'hAA);
    tick();
    wb.in_data = DATA_W'(8'hBB);
    tick();
    wb.in_valid = 1'b0;
    wb.dir_A = ADDR_W'(3); wb.signal_read = 1'b1;
    #1;
    n_checks++;
    if (wb.fwd_hit !== 1'b1 || wb.fwd_data !== DATA_W'(8'hBB)) begin
      n_errors++; $display("FAIL fwd_youngest: got %0h/%0h want 1/bb", wb.fwd_hit, wb.fwd_data);
    end
    wb.dir_A = ADDR_W'(2);
    #1;
    n_checks++;
    if (wb.fwd_hit !== 1'b0 || wb.fwd_data !== '0) begin
      n_errors++; $display("FAIL fwd_miss: got %0h/%0h want 0/0", wb.fwd_hit, wb.fwd_data);
    end
    wb.dir_A = ADDR_W'(3); wb.signal_read = 1'b0;
    #1;
    n_checks++;
    if (wb.fwd_hit !== 1'b0 || wb.fwd_data !== '0) begin
      n_errors++; $display("FAIL fwd_noread: got %0h/%0h want 0/0", wb.fwd_hit, wb.fwd_data);
    end
    wb.bank_stall = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] exp_dir  [$];
    logic [DATA_W-1:0] exp_data [$];
    int writes = 0;
    wb.bank_stall = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        wb.in_valid = 1'b1;
        wb.in_dir   = ADDR_W'($urandom);
        wb.in_data  = DATA_W'(c);
        exp_dir.push_back(wb.in_dir);
        exp_data.push_back(wb.in_data);
      end else begin
        wb.in_valid = 1'b0;
      end
      tick();
      n_checks++;
      if (wb.count > CNT_W'(1)) begin
        n_errors++; $display("FAIL b2b_count%0d: got %0h want <=1", c, wb.count);
      end
      if (wb.signal_esc === 1'b1) begin
        n_checks++;
        if (exp_dir.size() == 0) begin
          n_errors++; $display("FAIL b2b_extra_write: got dir=%0h want none", wb.dir_esc);
        end else if (wb.dir_esc !== exp_dir[0] || wb.data !== exp_data[0]) begin
          n_errors++;
          $display("FAIL b2b_order%0d: got %0h/%0h want %0h/%0h", writes,
                   wb.dir_esc, wb.data, exp_dir[0], exp_data[0]);
        end
        if (exp_dir.size() != 0) begin
          void'(exp_dir.pop_front());
          void'(exp_data.pop_front());
        end
        writes++;
      end
    end
    n_checks++;
    if (writes != 10) begin
      n_errors++; $display("FAIL b2b_total: got %0d want 10", writes);
    end
  endtask

  task automatic test_outreg_forward();
    wb.bank_stall = 1'b0; wb.signal_read = 1'b0;
    wb.in_valid = 1'b1; wb.in_dir = ADDR_W'(7); wb.in_data = DATA_W'(8'h5A);
    tick();
    wb.in_valid = 1'b0;
    tick();
    wb.dir_A = ADDR_W'(7); wb.signal_read = 1'b1;
    #1;
    n_checks++;
    if (wb.signal_esc !== 1'b1 || wb.fwd_hit !== 1'b1 || wb.fwd_data !== DATA_W'(8'h5A)) begin
      n_errors++;
      $display("FAIL outreg_fwd: got esc=%0h hit=%0h data=%0h want 1/1/5a",
               wb.signal_esc, wb.fwd_hit, wb.fwd_data);
    end
    tick();
    n_checks++;
    if (wb.fwd_hit !== 1'b0 || wb.fwd_data !== '0) begin
      n_errors++; $display("FAIL outreg_after: got %0h/%0h want 0/0", wb.fwd_hit, wb.fwd_data);
    end
    wb.signal_read = 1'b0;
  endtask

  task automatic test_random();
    logic              e_hit;
    logic [DATA_W-1:0] e_fwd;
    for (int c = 0; c < 400; c++) begin
      wb.in_valid   = ($urandom_range(0, 3) != 0);
      wb.in_dir     = ADDR_W'($urandom);
      wb.in_data    = DATA_W'($urandom);
      wb.bank_stall = (c >= 150 && c < 200) ? 1'b1 : ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (wb.signal_esc !== m_esc || wb.dir_esc !== m_dir || wb.data !== m_data) begin
        n_errors++;
        $display("FAIL rand_write%0d: got %0h/%0h/%0h want %0h/%0h/%0h", c,
                 wb.signal_esc, wb.dir_esc, wb.data, m_esc, m_dir, m_data);
      end
      n_checks++;
      if (wb.count !== CNT_W'(q_dir.size()) || wb.in_ready !== (q_dir.size() < DEPTH)) begin
        n_errors++;
        $display("FAIL rand_count%0d: got cnt=%0h rdy=%0h want %0d", c,
                 wb.count, wb.in_ready, q_dir.size());
      end
      wb.dir_A       = ADDR_W'($urandom);
      wb.signal_read = ($urandom_range(0, 4) != 0);
      #1;
      model_fwd(e_hit, e_fwd);
      n_checks++;
      if (wb.fwd_hit !== e_hit || wb.fwd_data !== e_fwd) begin
        n_errors++;
        $display("FAIL rand_fwd%0d: got %0h/%0h want %0h/%0h", c,
                 wb.fwd_hit, wb.fwd_data, e_hit, e_fwd);
      end
    end
    wb.in_valid = 1'b0; wb.bank_stall = 1'b0; wb.signal_read = 1'b0;
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_async_reset();
    wb.bank_stall = 1'b1; wb.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb.in_dir = ADDR_W'(i + 2); wb.in_data = DATA_W'(8'hC0 + i);
      tick();
    end
    wb.in_valid = 1'b0; wb.bank_stall = 1'b0;
    tick();
    n_checks++;
    if (wb.signal_esc !== 1'b1 || wb.count !== CNT_W'(3)) begin
      n_errors++; $display("FAIL arst_setup: got esc=%0h cnt=%0h want 1/3", wb.signal_esc, wb.count);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (wb.signal_esc !== 1'b0 || wb.count !== '0 || wb.dir_esc !== '0 || wb.data !== '0) begin
      n_errors++;
      $display("FAIL arst_immediate: got esc=%0h cnt=%0h dir=%0h data=%0h want 0/0/0/0",
               wb.signal_esc, wb.count, wb.dir_esc, wb.data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (wb.signal_esc !== 1'b0 || wb.count !== '0) begin
        n_errors++;
        $display("FAIL arst_stale%0d: got esc=%0h cnt=%0h want 0/0", i, wb.signal_esc, wb.count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_stall_fill();
    test_forward();
    test_back_to_back();
    test_outreg_forward();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
